play_scheduler: RTL and testbench

- Sequences the mp3 playback engine from decoded Bluetooth command bytes.
- Owns the selected track index, the VS1003 SCI volume word and the pause state.
- Drives track-change and volume-update requests to the mp3 engine over req/ack handshakes, muting around every track switch.
- Sits between the UART byte decoder and the mp3/VGA blocks; its num/volume outputs replace the direct UART-derived ones.

---
 rtl/play_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_play_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_scheduler.sv
// play_scheduler: turns decoded command bytes into track/volume changes for
// the mp3 engine. Every track switch is muted, switched, then restored, each
// step waiting on the engine's req/ack handshake with a timeout fallback.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a command or a pending end-of-file advance
// EXEC    | decode the latched command byte (one cycle)
// VOL     | write {att,att} to the engine after a volume command
// MUTE    | write the mute word before switching tracks
// SWITCH  | num takes the pending track, request an engine restart
// RESTORE | write {att,att} back after the switch
module play_scheduler #(
  parameter logic [7:0]  INIT_ATT    = 8'h20,
  parameter logic [7:0]  VOL_STEP    = 8'h10,
  parameter logic [7:0]  MAX_ATT     = 8'hF0,
  parameter int          LOOP_ALL    = 1,
  parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000
) (
  input  logic        i_clk,
  input  logic        i_init,
  input  logic [7:0]  i_cmd_byte,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_track_done,
  output logic [1:0]  o_num,
  output logic [15:0] o_volume,
  output logic        o_paused,
  output logic        o_vol_req,
  input  logic        i_vol_ack,
  output logic        o_trk_req,
  input  logic        i_trk_ack,
  output logic        o_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXEC    = 3'd1;
  localparam logic [2:0] S_VOL     = 3'd2;
  localparam logic [2:0] S_MUTE    = 3'd3;
  localparam logic [2:0] S_SWITCH  = 3'd4;
  localparam logic [2:0] S_RESTORE = 3'd5;

  localparam logic [15:0] MUTE_WORD = 16'hFEFE;

  logic [2:0]  r_state;
  logic [7:0]  r_cmd;
  logic [1:0]  r_num;
  logic [1:0]  r_pend_trk;
  logic [7:0]  r_att;
  logic [15:0] r_volume;
  logic        r_paused;
  logic        r_vol_req;
  logic        r_trk_req;
  logic        r_err;
  logic        r_done_pend;
  logic [23:0] r_cnt;

  logic        w_req;
  logic        w_ack;
  logic        w_cnt_end;
  logic        w_adv;
  logic        w_tmo;
  logic [7:0]  w_att_up;
  logic [7:0]  w_att_dn;
  logic [8:0]  w_att_sum;
  logic        w_is_trk;
  logic [1:0]  w_tgt;

  // Handshake bookkeeping and command decode helpers.
  always_comb begin
    w_req     = r_vol_req | r_trk_req;
    w_ack     = (r_state == S_SWITCH) ? i_trk_ack : i_vol_ack;
    w_cnt_end = (r_cnt == ACK_TIMEOUT - 24'd1);
    // An ack seen before req is up is ignored because w_req gates both paths.
    w_adv     = w_req & (w_ack | w_cnt_end);
    w_tmo     = w_req & ~w_ack & w_cnt_end;
    w_att_up  = (r_att >= VOL_STEP) ? (r_att - VOL_STEP) : 8'h00;
    w_att_sum = {1'b0, r_att} + {1'b0, VOL_STEP};
    w_att_dn  = (w_att_sum > {1'b0, MAX_ATT}) ? MAX_ATT : w_att_sum[7:0];
    w_is_trk  = (r_cmd == 8'h02) || (r_cmd == 8'h03) || (r_cmd[7:2] == 6'b000100);
    w_tgt     = r_cmd[1:0];
    if (r_cmd == 8'h02) begin
      w_tgt = r_num + 2'd1;
    end else if (r_cmd == 8'h03) begin
      w_tgt = r_num - 2'd1;
    end
  end

  // Sequencer state, owned playback settings and engine requests.
  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'h00;
      r_num       <= 2'd0;
      r_pend_trk  <= 2'd0;
      r_att       <= INIT_ATT;
      r_volume    <= {INIT_ATT, INIT_ATT};
      r_paused    <= 1'b0;
      r_vol_req   <= 1'b0;
      r_trk_req   <= 1'b0;
      r_err       <= 1'b0;
      r_done_pend <= 1'b0;
      r_cnt       <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_cmd   <= i_cmd_byte;
            r_state <= S_EXEC;
          end else if (r_done_pend && !r_paused) begin
            r_done_pend <= 1'b0;
            if (LOOP_ALL == 0 && r_num == 2'd3) begin
              r_paused <= 1'b1;
            end else begin
              r_pend_trk <= r_num + 2'd1;
              r_cnt      <= 24'd0;
              r_state    <= S_MUTE;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= 24'd0;
          if (r_cmd == 8'h01) begin
            r_paused <= ~r_paused;
            r_state  <= S_IDLE;
          end else if (r_cmd == 8'h04) begin
            r_att   <= w_att_up;
            r_state <= S_VOL;
          end else if (r_cmd == 8'h05) begin
            r_att   <= w_att_dn;
            r_state <= S_VOL;
          end else if (w_is_trk && (w_tgt != r_num)) begin
            r_pend_trk <= w_tgt;
            r_state    <= S_MUTE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_VOL, S_MUTE, S_SWITCH, S_RESTORE: begin
          if (!w_req) begin
            // Entry cycle: present the data, raise req on the next edge.
            if (r_state == S_SWITCH) begin
              r_trk_req <= 1'b1;
            end else begin
              r_vol_req <= 1'b1;
              r_volume  <= (r_state == S_MUTE) ? MUTE_WORD : {r_att, r_att};
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
            if (w_adv) begin
              r_vol_req <= 1'b0;
              r_trk_req <= 1'b0;
              r_cnt     <= 24'd0;
              if (w_tmo) begin
                r_err <= 1'b1;
              end
              case (r_state)
                S_MUTE: begin
                  r_num   <= r_pend_trk;
                  r_state <= S_SWITCH;
                end
                S_SWITCH: r_state <= S_RESTORE;
                default:  r_state <= S_IDLE;
              endcase
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed last so an end-of-file pulse is never dropped by a clear above.
      if (i_track_done) begin
        r_done_pend <= 1'b1;
      end
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_num       = r_num;
  assign o_volume    = r_volume;
  assign o_paused    = r_paused;
  assign o_vol_req   = r_vol_req;
  assign o_trk_req   = r_trk_req;
  assign o_err       = r_err;

endmodule

// File: tb/tb_play_scheduler.sv
// Bench for play_scheduler: expected engine transactions are queued as each
// command is issued and popped by a monitor on every rising req.
module tb_play_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init, cmd_valid, track_done, hold_ack;
  logic [7:0]  cmd_byte;
  logic        vol_ack, trk_ack, vol_ack0, trk_ack0;

  logic        o_cmd_ready, o_paused, o_vol_req, o_trk_req, o_err;
  logic [1:0]  o_num;
  logic [15:0] o_volume;
  logic        o_cmd_ready0, o_paused0, o_vol_req0, o_trk_req0, o_err0;
  logic [1:0]  o_num0;
  logic [15:0] o_volume0;

  play_scheduler #(.LOOP_ALL(1), .ACK_TIMEOUT(24'd16)) u_dut (
    .i_clk(clk), .i_init(init), .i_cmd_byte(cmd_byte), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_track_done(track_done), .o_num(o_num),
    .o_volume(o_volume), .o_paused(o_paused), .o_vol_req(o_vol_req),
    .i_vol_ack(vol_ack), .o_trk_req(o_trk_req), .i_trk_ack(trk_ack), .o_err(o_err)
  );

  play_scheduler #(.LOOP_ALL(0), .ACK_TIMEOUT(24'd16)) u_dut0 (
    .i_clk(clk), .i_init(init), .i_cmd_byte(cmd_byte), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(o_cmd_ready0), .i_track_done(track_done), .o_num(o_num0),
    .o_volume(o_volume0), .o_paused(o_paused0), .o_vol_req(o_vol_req0),
    .i_vol_ack(vol_ack0), .o_trk_req(o_trk_req0), .i_trk_ack(trk_ack0), .o_err(o_err0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Transaction word: {is_trk, cmd_ready, data}; cmd_ready must be low mid-sequence.
  task automatic push_vol(input logic [15:0] v);
    exp_q.push_back({1'b0, 1'b0, v});
  endtask

  task automatic push_trk(input logic [1:0] n);
    exp_q.push_back({1'b1, 1'b0, 14'd0, n});
  endtask

  task automatic push_switch(input logic [1:0] n, input logic [15:0] restore);
    push_vol(16'hFEFE);
    push_trk(n);
    push_vol(restore);
  endtask

  task automatic take(input logic [17:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: got %0h, expected no transaction", obs);
    end else begin
      chk("sb_xact", {14'd0, obs}, {14'd0, exp_q.pop_front()});
    end
  endtask

  // Monitor: one transaction per rising req on the LOOP_ALL=1 instance.
  logic pv = 1'b0, pt = 1'b0;
  always @(negedge clk) begin
    if (o_vol_req && !pv) take({1'b0, o_cmd_ready, o_volume});
    if (o_trk_req && !pt) take({1'b1, o_cmd_ready, 14'd0, o_num});
    pv <= o_vol_req;
    pt <= o_trk_req;
  end

  // Engine model for the main instance: ack 3 cycles after req, or never while held.
  initial begin
    int c;
    c = 0; vol_ack = 1'b0; trk_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (vol_ack || trk_ack) begin
        vol_ack = 1'b0; trk_ack = 1'b0; c = 0;
      end else if (!hold_ack && (o_vol_req || o_trk_req)) begin
        c++;
        if (c == 3) begin vol_ack = o_vol_req; trk_ack = o_trk_req; end
      end else begin
        c = 0;
      end
    end
  end

  // Engine model for the LOOP_ALL=0 instance.
  initial begin
    int c;
    c = 0; vol_ack0 = 1'b0; trk_ack0 = 1'b0;
    forever begin
      @(negedge clk);
      if (vol_ack0 || trk_ack0) begin
        vol_ack0 = 1'b0; trk_ack0 = 1'b0; c = 0;
      end else if (o_vol_req0 || o_trk_req0) begin
        c++;
        if (c == 3) begin vol_ack0 = o_vol_req0; trk_ack0 = o_trk_req0; end
      end else begin
        c = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic td);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!o_cmd_ready) chk("send_ready", {31'd0, o_cmd_ready}, 32'd1);
    cmd_byte = b; cmd_valid = 1'b1; track_done = td;
    @(negedge clk);
    cmd_valid = 1'b0; track_done = 1'b0;
  endtask

  task automatic wait_quiet();
    int q, n;
    q = 0; n = 0;
    while (q < 3 && n < 400) begin
      @(negedge clk); n++;
      if (exp_q.size() == 0 && o_cmd_ready && !o_vol_req && !o_trk_req) q++;
      else q = 0;
    end
    chk("quiet", {31'd0, q >= 3}, 32'd1);
  endtask

  task automatic wait_vol_req();
    int n;
    n = 0;
    while (!o_vol_req && n < 200) begin @(negedge clk); n++; end
    chk("wait_vol_req", {31'd0, o_vol_req}, 32'd1);
  endtask

  task automatic wait_trk_req();
    int n;
    n = 0;
    while (!o_trk_req && n < 200) begin @(negedge clk); n++; end
    chk("wait_trk_req", {31'd0, o_trk_req}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_num"},   {30'd0, o_num}, 32'd0);
    chk({tag, "_vol"},   {16'd0, o_volume}, 32'h2020);
    chk({tag, "_pause"}, {31'd0, o_paused}, 32'd0);
    chk({tag, "_err"},   {31'd0, o_err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_cmd_ready}, 32'd1);
    chk({tag, "_vreq"},  {31'd0, o_vol_req}, 32'd0);
    chk({tag, "_treq"},  {31'd0, o_trk_req}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic [15:0] steps [5];
    steps[0] = 16'h3030; steps[1] = 16'h2020; steps[2] = 16'h1010;
    steps[3] = 16'h0000; steps[4] = 16'h0000;

    init = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; track_done = 1'b0; hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    init = 1'b0;

    // Volume down twice, then up five times with saturation at 0.
    push_vol(16'h3030); send(8'h05, 1'b0);
    push_vol(16'h4040); send(8'h05, 1'b0);
    wait_quiet();
    chk("vol_dn2", {16'd0, o_volume}, 32'h4040);
    for (int i = 0; i < 5; i++) begin
      push_vol(steps[i]);
      send(8'h04, 1'b0);
    end
    wait_quiet();
    chk("vol_up_sat", {16'd0, o_volume}, 32'h0000);

    // Fresh start, then a selected track switch.
    @(negedge clk); init = 1'b1; @(negedge clk); init = 1'b0;
    push_switch(2'd2, 16'h2020); send(8'h12, 1'b0);
    wait_quiet();
    chk("sel2_num", {30'd0, o_num}, 32'd2);

    push_switch(2'd0, 16'h2020); send(8'h10, 1'b0);
    push_switch(2'd3, 16'h2020); send(8'h03, 1'b0);
    wait_quiet();
    chk("prev_wrap", {30'd0, o_num}, 32'd3);
    push_switch(2'd0, 16'h2020); send(8'h02, 1'b0);
    wait_quiet();
    chk("next_wrap", {30'd0, o_num}, 32'd0);
    push_switch(2'd1, 16'h2020); send(8'h11, 1'b0);
    wait_quiet();

    // Selecting the current track: EXEC then straight back to IDLE.
    send(8'h11, 1'b0);
    chk("same_exec", {31'd0, o_cmd_ready}, 32'd0);
    @(negedge clk);
    chk("same_idle", {31'd0, o_cmd_ready}, 32'd1);
    chk("same_noreq", {31'd0, o_vol_req}, 32'd0);
    send(8'h77, 1'b0);
    wait_quiet();
    chk("inval_num", {30'd0, o_num}, 32'd1);
    push_switch(2'd2, 16'h2020); send(8'h02, 1'b0);
    wait_quiet();

    // End-of-file during a switch to track 3.
    push_switch(2'd3, 16'h2020);
    push_switch(2'd0, 16'h2020);
    send(8'h13, 1'b0);
    wait_vol_req();
    track_done = 1'b1; @(negedge clk); track_done = 1'b0;
    wait_quiet();
    chk("loop_num", {30'd0, o_num}, 32'd0);
    chk("loop_pause", {31'd0, o_paused}, 32'd0);
    chk("hold_num", {30'd0, o_num0}, 32'd3);
    chk("hold_pause", {31'd0, o_paused0}, 32'd1);
    chk("hold_noreq", {30'd0, o_vol_req0, o_trk_req0}, 32'd0);

    // Pause keeps a pending end-of-file until resumed.
    send(8'h01, 1'b0);
    @(negedge clk);
    chk("paused", {31'd0, o_paused}, 32'd1);
    track_done = 1'b1; @(negedge clk); track_done = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | o_vol_req | o_trk_req; end
    chk("paused_noreq", {31'd0, seen}, 32'd0);
    chk("paused_num", {30'd0, o_num}, 32'd0);
    push_switch(2'd1, 16'h2020); send(8'h01, 1'b0);
    wait_quiet();
    chk("resume_num", {30'd0, o_num}, 32'd1);
    chk("resume_pause", {31'd0, o_paused}, 32'd0);

    // Command and end-of-file in the same IDLE cycle: command first.
    push_vol(16'h3030);
    push_switch(2'd2, 16'h3030);
    send(8'h05, 1'b1);
    wait_quiet();
    chk("both_num", {30'd0, o_num}, 32'd2);
    chk("both_vol", {16'd0, o_volume}, 32'h3030);
    chk("no_err", {31'd0, o_err}, 32'd0);

    // Ack timeout in MUTE, then init in SWITCH.
    hold_ack = 1'b1;
    push_vol(16'hFEFE);
    push_trk(2'd3);
    send(8'h13, 1'b0);
    wait_vol_req();
    n = 0;
    while (o_vol_req && n < 100) begin n++; @(negedge clk); end
    chk("tmo_cycles", n, 32'd16);
    chk("tmo_err", {31'd0, o_err}, 32'd1);
    chk("tmo_num", {30'd0, o_num}, 32'd3);
    chk("tmo_ready", {31'd0, o_cmd_ready}, 32'd0);
    wait_trk_req();
    init = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    init = 1'b0; hold_ack = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | o_vol_req | o_trk_req; end
    chk("abort_norestore", {31'd0, seen}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
